// File: rtl/instruction_control_unit.sv
// Multi-cycle instruction sequencer feeding the register file, ALU and data memory handshakes.
// Optional ALU watchdog enabled by defining INSTRUCTION_CONTROL_ALU_TIMEOUT_EN.
module instruction_control_unit #(
   parameter logic [31:0] PC_RESET    = 32'h0000_0000,
   parameter logic [31:0] PC_STEP     = 32'd4
`ifdef INSTRUCTION_CONTROL_ALU_TIMEOUT_EN
   ,
   parameter int unsigned ALU_TIMEOUT = 16
`endif
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] instruction_in,
   input  logic        instruction_valid,
   output logic        instruction_ready,
   output logic [31:0] instruction,
   output logic [4:0]  address1,
   output logic [4:0]  address2,
   output logic        enable_read,
   output logic        enable_write,
   output logic [4:0]  alu_opcode,
   output logic        alu_start,
   input  logic        alu_done,
   output logic        memory_read,
   output logic        memory_write,
   input  logic        memory_done,
`ifdef INSTRUCTION_CONTROL_ALU_TIMEOUT_EN
   output logic        alu_timeout,
`endif
   output logic [31:0] pc,
   output logic        illegal_opcode
);

   localparam logic [2:0] S_FETCH     = 3'd0;
   localparam logic [2:0] S_DECODE    = 3'd1;
   localparam logic [2:0] S_READ      = 3'd2;
   localparam logic [2:0] S_EXECUTE   = 3'd3;
   localparam logic [2:0] S_MEMORY    = 3'd4;
   localparam logic [2:0] S_WRITEBACK = 3'd5;
   localparam logic [2:0] S_RETIRE    = 3'd6;

   localparam logic [4:0] OP_LW   = 5'd0;
   localparam logic [4:0] OP_SW   = 5'd1;
   localparam logic [4:0] OP_MOV  = 5'd2;
   localparam logic [4:0] OP_CMP  = 5'd11;
   localparam logic [4:0] OP_LAST = 5'd12;

   logic [2:0]  state_reg, state_next;
   logic [31:0] instr_reg, instr_next;
   logic [31:0] pc_reg, pc_next;
   logic        illegal_reg, illegal_next;
   logic        exec_first_reg, exec_first_next;
   logic [4:0]  opcode;

   assign opcode = instr_reg[31:27];

`ifdef INSTRUCTION_CONTROL_ALU_TIMEOUT_EN
   localparam int CNT_W = $clog2(ALU_TIMEOUT + 1);
   logic [CNT_W-1:0] tmo_cnt_reg, tmo_cnt_next;
   logic             tmo_hit;

   // Expires in the ALU_TIMEOUT-th EXECUTE cycle unless the ALU answers in that same cycle.
   assign tmo_hit     = (state_reg == S_EXECUTE) && !alu_done
                        && (tmo_cnt_reg == CNT_W'(ALU_TIMEOUT - 1));
   assign alu_timeout = tmo_hit;
   assign tmo_cnt_next = (state_reg == S_EXECUTE) ? tmo_cnt_reg + 1'b1 : '0;
`endif

   always_comb begin
      state_next      = state_reg;
      instr_next      = instr_reg;
      pc_next         = pc_reg;
      illegal_next    = illegal_reg;
      exec_first_next = 1'b0;
      case (state_reg)
         S_FETCH: begin
            if (instruction_valid) begin
               instr_next = instruction_in;
               state_next = S_DECODE;
            end
         end
         S_DECODE: begin
            if (opcode > OP_LAST) begin
               illegal_next = 1'b1;
               pc_next      = pc_reg + PC_STEP;
               state_next   = S_FETCH;
            end else begin
               state_next = S_READ;
            end
         end
         S_READ: begin
            if (opcode == OP_LW || opcode == OP_SW) begin
               state_next = S_MEMORY;
            end else if (opcode == OP_MOV) begin
               state_next = S_WRITEBACK;
            end else begin
               state_next      = S_EXECUTE;
               exec_first_next = 1'b1;
            end
         end
         S_EXECUTE: begin
            if (alu_done) begin
               state_next = (opcode == OP_CMP) ? S_RETIRE : S_WRITEBACK;
            end
`ifdef INSTRUCTION_CONTROL_ALU_TIMEOUT_EN
            else if (tmo_hit) begin
               state_next = S_RETIRE;
            end
`endif
         end
         S_MEMORY: begin
            if (memory_done) begin
               state_next = (opcode == OP_LW) ? S_WRITEBACK : S_RETIRE;
            end
         end
         S_WRITEBACK: state_next = S_RETIRE;
         S_RETIRE: begin
            pc_next    = pc_reg + PC_STEP;
            state_next = S_FETCH;
         end
         default: state_next = S_FETCH;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg      <= S_FETCH;
         instr_reg      <= '0;
         pc_reg         <= PC_RESET;
         illegal_reg    <= 1'b0;
         exec_first_reg <= 1'b0;
`ifdef INSTRUCTION_CONTROL_ALU_TIMEOUT_EN
         tmo_cnt_reg    <= '0;
`endif
      end else begin
         state_reg      <= state_next;
         instr_reg      <= instr_next;
         pc_reg         <= pc_next;
         illegal_reg    <= illegal_next;
         exec_first_reg <= exec_first_next;
`ifdef INSTRUCTION_CONTROL_ALU_TIMEOUT_EN
         tmo_cnt_reg    <= tmo_cnt_next;
`endif
      end
   end

   // Strobes decode straight from state so a reset leaves every one of them low next cycle.
   assign instruction_ready = (state_reg == S_FETCH);
   assign enable_read       = (state_reg == S_READ);
   assign enable_write      = (state_reg == S_WRITEBACK);
   assign alu_start         = (state_reg == S_EXECUTE) && exec_first_reg;
   assign memory_read       = (state_reg == S_MEMORY) && (opcode == OP_LW);
   assign memory_write      = (state_reg == S_MEMORY) && (opcode == OP_SW);

   assign instruction    = instr_reg;
   assign address1       = instr_reg[21:17];
   assign address2       = instr_reg[4:0];
   assign alu_opcode     = opcode;
   assign pc             = pc_reg;
   assign illegal_opcode = illegal_reg;

endmodule

// File: tb/tb_instruction_control_unit.sv
// Directed bench for instruction_control_unit: per-cycle schedule model plus literal spot checks.
`timescale 1ns/1ps
module tb_instruction_control_unit;

   localparam logic [31:0] PC_RESET = 32'h0000_0000;
   localparam int NEVER = 255;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] instruction_in = '0;
   logic        instruction_valid = 1'b0;
   logic        instruction_ready;
   logic [31:0] instruction;
   logic [4:0]  address1, address2, alu_opcode;
   logic        enable_read, enable_write, alu_start, alu_done;
   logic        memory_read, memory_write, memory_done;
   logic [31:0] pc;
   logic        illegal_opcode;
   logic        tmo;

   instruction_control_unit dut (
      .clock            (clock),
      .reset            (reset),
      .instruction_in   (instruction_in),
      .instruction_valid(instruction_valid),
      .instruction_ready(instruction_ready),
      .instruction      (instruction),
      .address1         (address1),
      .address2         (address2),
      .enable_read      (enable_read),
      .enable_write     (enable_write),
      .alu_opcode       (alu_opcode),
      .alu_start        (alu_start),
      .alu_done         (alu_done),
      .memory_read      (memory_read),
      .memory_write     (memory_write),
      .memory_done      (memory_done),
`ifdef INSTRUCTION_CONTROL_ALU_TIMEOUT_EN
      .alu_timeout      (tmo),
`endif
      .pc               (pc),
      .illegal_opcode   (illegal_opcode)
   );
`ifndef INSTRUCTION_CONTROL_ALU_TIMEOUT_EN
   assign tmo = 1'b0;
`endif

   always #5 clock = ~clock;

   int pass_cnt = 0;
   int total_cnt = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
   endtask

   // ---------------- responders: ALU and memory ----------------
   int alu_delay = 0, mem_delay = 0;
   int alu_cnt = 0, mem_cnt = 0;
   bit alu_pend = 0, mem_pend = 0;
   initial begin
      alu_done = 1'b0;
      memory_done = 1'b0;
   end

   always @(negedge clock) begin
      if (reset) begin
         alu_pend = 0; mem_pend = 0;
      end
      if (alu_start && alu_delay != NEVER) begin
         alu_pend = 1; alu_cnt = alu_delay;
      end
      alu_done = alu_pend && alu_cnt == 0;
      if (alu_pend) begin
         if (alu_cnt == 0) alu_pend = 0; else alu_cnt--;
      end
      if ((memory_read || memory_write) && !mem_pend) begin
         mem_pend = 1; mem_cnt = mem_delay;
      end
      memory_done = mem_pend && mem_cnt == 0;
      if (mem_pend) begin
         if (mem_cnt == 0) mem_pend = 0; else mem_cnt--;
      end
   end

   // ---------------- model: expected cycle schedule per instruction ----------------
   typedef struct packed {
      logic        ready, rd, wr, start, mrd, mwr, to;
      logic [31:0] pc;
      logic        ill;
   } exp_t;

   exp_t        q[$];
   exp_t        cur;
   logic [31:0] pc_m = PC_RESET;
   logic [31:0] instr_m = '0;
   logic        ill_m = 1'b0;
   bit          model_on = 0;

   function automatic exp_t mk(input bit ready, rd, wr, start, mrd, mwr, to,
                               input logic [31:0] p, input logic il);
      exp_t e;
      e = '{ready, rd, wr, start, mrd, mwr, to, p, il};
      return e;
   endfunction

   task automatic build(input logic [31:0] instr);
      logic [4:0]  op;
      logic [31:0] pc0;
      int          n;
      op      = instr[31:27];
      pc0     = pc_m;
      instr_m = instr;
      q.push_back(mk(0, 0, 0, 0, 0, 0, 0, pc0, ill_m));             // decode
      if (op > 12) begin
         ill_m = 1'b1;
         pc_m  = pc0 + 32'd4;
         return;
      end
      q.push_back(mk(0, 1, 0, 0, 0, 0, 0, pc0, ill_m));             // register read
      if (op <= 1) begin
         for (int i = 0; i <= mem_delay; i++)
            q.push_back(mk(0, 0, 0, 0, op == 0, op == 1, 0, pc0, ill_m));
         if (op == 0) q.push_back(mk(0, 0, 1, 0, 0, 0, 0, pc0, ill_m));
      end else if (op == 2) begin
         q.push_back(mk(0, 0, 1, 0, 0, 0, 0, pc0, ill_m));
      end else begin
         n = (alu_delay == NEVER) ? 16 : alu_delay + 1;
         for (int i = 0; i < n; i++)
            q.push_back(mk(0, 0, 0, i == 0, 0, 0, alu_delay == NEVER && i == n - 1, pc0, ill_m));
         if (alu_delay != NEVER && op != 11) q.push_back(mk(0, 0, 1, 0, 0, 0, 0, pc0, ill_m));
      end
      q.push_back(mk(0, 0, 0, 0, 0, 0, 0, pc0, ill_m));             // retire
      pc_m = pc0 + 32'd4;
   endtask

   always @(posedge clock) begin
      if (reset) begin
         q.delete();
         pc_m = PC_RESET; ill_m = 1'b0; instr_m = '0;
         model_on = 1;
         cur = mk(1, 0, 0, 0, 0, 0, 0, pc_m, ill_m);
      end else if (model_on) begin
         if (q.size() > 0) cur = q.pop_front();
         else if (cur.ready && instruction_valid) begin
            build(instruction_in);
            cur = q.pop_front();
         end else cur = mk(1, 0, 0, 0, 0, 0, 0, pc_m, ill_m);
      end
   end

   // ---------------- per-cycle compare and pulse counters ----------------
   int wr_cnt = 0, rd_cnt = 0, start_cnt = 0, mrd_cyc = 0, mwr_cyc = 0, tmo_cnt = 0;
   always @(negedge clock) begin
      exp_t act;
      if (model_on) begin
         act = '{instruction_ready, enable_read, enable_write, alu_start,
                 memory_read, memory_write, tmo, pc, illegal_opcode};
         chk("cycle{rdy,rd,wr,st,mr,mw,to,pc,ill}", 64'(act), 64'(cur));
         chk("fields{instr,a1,a2,op}", 64'({instruction, address1, address2, alu_opcode}),
             64'({instr_m, instr_m[21:17], instr_m[4:0], instr_m[31:27]}));
      end
      wr_cnt    += int'(enable_write);
      rd_cnt    += int'(enable_read);
      start_cnt += int'(alu_start);
      mrd_cyc   += int'(memory_read);
      mwr_cyc   += int'(memory_write);
      tmo_cnt   += int'(tmo);
   end

   // ---------------- stimulus ----------------
   task automatic clear_counts();
      wr_cnt = 0; rd_cnt = 0; start_cnt = 0; mrd_cyc = 0; mwr_cyc = 0; tmo_cnt = 0;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      instruction_valid = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic wait_ready(output int cyc);
      cyc = 0;
      while (!instruction_ready && cyc < 200) begin
         @(negedge clock);
         cyc++;
      end
      if (!instruction_ready) begin
         total_cnt++;
         $display("FAIL wait_ready actual=not_ready required=ready_within_200");
      end
   endtask

   task automatic issue(input logic [31:0] instr, output int lat);
      int c;
      wait_ready(c);
      instruction_in = instr;
      instruction_valid = 1'b1;
      @(negedge clock);
      instruction_valid = 1'b0;
      wait_ready(c);
      lat = c;
   endtask

   initial begin
      int lat;
      do_reset();
      chk("reset_ready", 64'(instruction_ready), 64'd1);
      chk("reset_pc", 64'(pc), 64'(PC_RESET));
      chk("reset_instr", 64'(instruction), 64'd0);
      chk("reset_strobes", 64'({enable_read, enable_write, alu_start, memory_read, memory_write}), 64'd0);

      // ADD with alu_done two cycles after alu_start
      clear_counts();
      alu_delay = 2;
      issue(32'h18C4_0002, lat);
      chk("add_lat", 64'(lat), 64'd7);
      chk("add_rd", 64'(rd_cnt), 64'd1);
      chk("add_start", 64'(start_cnt), 64'd1);
      chk("add_wr", 64'(wr_cnt), 64'd1);
      chk("add_pc", 64'(pc), 64'd4);
      $display("ADD   instr=18c40002 lat=%0d pc=%0h", lat, pc);

      // LW then SW, memory_done after three wait cycles
      do_reset();
      clear_counts();
      mem_delay = 3;
      issue(32'h0006_0005, lat);
      chk("lw_lat", 64'(lat), 64'd8);
      chk("lw_mrd_cycles", 64'(mrd_cyc), 64'd4);
      chk("lw_wr", 64'(wr_cnt), 64'd1);
      chk("lw_pc", 64'(pc), 64'd4);
      $display("LW    instr=00060005 lat=%0d pc=%0h", lat, pc);
      clear_counts();
      issue(32'h0806_0005, lat);
      chk("sw_mwr_cycles", 64'(mwr_cyc), 64'd4);
      chk("sw_wr", 64'(wr_cnt), 64'd0);
      chk("sw_pc", 64'(pc), 64'd8);
      $display("SW    instr=08060005 lat=%0d pc=%0h", lat, pc);

      // MOV then CMP with instruction_valid held high throughout
      do_reset();
      clear_counts();
      alu_delay = 0;
      wait_ready(lat);
      instruction_in = 32'h1000_0001;
      instruction_valid = 1'b1;
      @(negedge clock);
      wait_ready(lat);
      chk("mov_lat", 64'(lat), 64'd4);
      $display("MOV   instr=10000001 lat=%0d pc=%0h", lat, pc);
      instruction_in = 32'h5804_0003;
      @(negedge clock);
      instruction_valid = 1'b0;
      wait_ready(lat);
      chk("cmp_start", 64'(start_cnt), 64'd1);
      chk("movcmp_wr", 64'(wr_cnt), 64'd1);
      chk("movcmp_pc", 64'(pc), 64'd8);
      $display("CMP   instr=58040003 lat=%0d pc=%0h", lat, pc);

      // AND with immediate alu_done: minimum ALU latency
      issue(32'h3822_0004, lat);
      chk("and_lat", 64'(lat), 64'd5);
      $display("AND   instr=38220004 lat=%0d pc=%0h", lat, pc);

      // illegal opcode 31, then a legal MOV keeps the sticky flag
      clear_counts();
      issue(32'hF800_0007, lat);
      chk("ill_flag", 64'(illegal_opcode), 64'd1);
      chk("ill_pc", 64'(pc), 64'd16);
      chk("ill_no_rw", 64'(rd_cnt + wr_cnt), 64'd0);
      $display("ILL   instr=f8000007 lat=%0d pc=%0h", lat, pc);
      issue(32'h1002_0009, lat);
      chk("ill_sticky", 64'(illegal_opcode), 64'd1);
      $display("MOV   instr=10020009 lat=%0d pc=%0h", lat, pc);

      // reset while LW waits in MEMORY
      mem_delay = 10;
      wait_ready(lat);
      instruction_in = 32'h0004_0001;
      instruction_valid = 1'b1;
      @(negedge clock);
      instruction_valid = 1'b0;
      lat = 0;
      while (!memory_read && lat < 20) begin
         @(negedge clock);
         lat++;
      end
      chk("lw_in_memory", 64'(memory_read), 64'd1);
      reset = 1'b1;
      @(negedge clock);
      chk("rst_mid_mrd", 64'(memory_read), 64'd0);
      chk("rst_mid_pc", 64'(pc), 64'(PC_RESET));
      chk("rst_mid_ready", 64'(instruction_ready), 64'd1);
      chk("rst_mid_ill", 64'(illegal_opcode), 64'd0);
      reset = 1'b0;
      $display("RST   mid-MEMORY pc=%0h ready=%0b", pc, instruction_ready);

`ifdef INSTRUCTION_CONTROL_ALU_TIMEOUT_EN
      // DIV whose ALU never answers
      clear_counts();
      alu_delay = NEVER;
      issue(32'h3002_0001, lat);
      chk("div_lat", 64'(lat), 64'd19);
      chk("div_tmo", 64'(tmo_cnt), 64'd1);
      chk("div_wr", 64'(wr_cnt), 64'd0);
      chk("div_pc", 64'(pc), 64'd4);
      $display("DIV   instr=30020001 lat=%0d pc=%0h timeout", lat, pc);
      alu_delay = 0;
`endif

      repeat (3) @(negedge clock);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
